// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding, default widths and the 8-bit CLA slice for the MAC back-end.
package mac_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int LEN_W  = 8;
    // Returns {cout, sum}; every carry is formed directly from g/p/cin, not rippled.
    function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [7:0] g, p;
        logic [8:0] c;
        logic pp;
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
        return {c[8], p ^ c[7:0]};
    endfunction
endpackage

// File: rtl/acc_adder.sv
// acc_adder: ACC_W-bit adder chained from 8-bit CLA slices; cout is the carry out of bit ACC_W-1.
module acc_adder import mac_pkg::*; #(
    parameter int ACC_W = mac_pkg::ACC_W
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_cout
);
    localparam int NS = (ACC_W + 7) / 8;
    localparam int PW = NS * 8;
    logic [PW-1:0] w_a, w_b, w_s;
    logic [NS:0]   w_c;
    logic [PW:0]   w_ext;
    assign w_a    = PW'(i_a);
    assign w_b    = PW'(i_b);
    assign w_c[0] = 1'b0;
    for (genvar s = 0; s < NS; s++) begin : g_slice
        assign {w_c[s+1], w_s[s*8 +: 8]} = cla8(w_a[s*8 +: 8], w_b[s*8 +: 8], w_c[s]);
    end
    // Padding bits are zero, so above bit ACC_W-1 only the carry itself can surface.
    assign w_ext  = {w_c[NS], w_s};
    assign o_sum  = w_s[ACC_W-1:0];
    assign o_cout = |w_ext[PW:ACC_W];
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed number of multiplier products and holds the result
// behind a valid/ready output handshake, flagging any wrap of the accumulator.
module product_accumulator import mac_pkg::*; #(
    parameter int PROD_W = mac_pkg::PROD_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int LEN_W  = mac_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    state_t             r_state;
    logic [LEN_W-1:0]   r_count;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [ACC_W-1:0]   w_sum;
    logic               w_cout;
    acc_adder #(.ACC_W(ACC_W)) u_add (
        .i_a    (r_acc),
        .i_b    (ACC_W'(prod)),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_count <= len;
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= (len == '0) ? DONE : ACCUM;
                end
                ACCUM: if (prod_valid) begin
                    r_acc   <= w_sum;
                    r_ovf   <= r_ovf | w_cout;
                    r_count <= r_count - 1'b1;
                    if (r_count == LEN_W'(1)) r_state <= DONE;
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign prod_ready = (r_state == ACCUM);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign acc        = r_acc;
    assign ovf        = r_ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed runs with hand-computed sums on a 24-bit and a 17-bit instance.
module tb_product_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [15:0] prod = '0;
    logic        prod_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        prod_ready, ovf, out_valid, busy;
    logic [23:0] acc;
    logic        prod_ready_s, ovf_s, out_valid_s, busy_s;
    logic [16:0] acc_s;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .acc(acc), .ovf(ovf), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );
    product_accumulator #(.ACC_W(17)) dut_s (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready_s), .acc(acc_s), .ovf(ovf_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .busy(busy_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] p);
        prod       = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_acc", 32'(acc), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_prod_ready", 32'(prod_ready), 0);
        chk("rst_busy", 32'(busy), 0);

        // basic sum, back-to-back products, consumer always ready
        out_ready = 1'b1;
        begin_run(8'd4);
        chk("basic_prod_ready", 32'(prod_ready), 1);
        chk("basic_busy", 32'(busy), 1);
        feed(16'd100);
        feed(16'd200);
        feed(16'd300);
        chk("basic_not_done_yet", 32'(out_valid), 0);
        feed(16'd400);
        chk("basic_out_valid", 32'(out_valid), 1);
        chk("basic_acc", 32'(acc), 1000);
        chk("basic_ovf", 32'(ovf), 0);
        chk("basic_prod_ready_done", 32'(prod_ready), 0);
        tick();
        chk("basic_idle_valid", 32'(out_valid), 0);
        chk("basic_idle_busy", 32'(busy), 0);
        chk("basic_acc_kept", 32'(acc), 1000);

        // overflow: 3 * 65535 = 196605 wraps in 17 bits to 65533, fits in 24 bits
        begin_run(8'd3);
        feed(16'hFFFF);
        feed(16'hFFFF);
        feed(16'hFFFF);
        chk("ovf17_valid", 32'(out_valid_s), 1);
        chk("ovf17_acc", 32'(acc_s), 65533);
        chk("ovf17_flag", 32'(ovf_s), 1);
        chk("ovf24_acc", 32'(acc), 196605);
        chk("ovf24_flag", 32'(ovf), 0);
        tick();

        // stalls on input and backpressure on output
        out_ready = 1'b0;
        begin_run(8'd2);
        for (int i = 0; i < 3; i++) tick();
        chk("stall_prod_ready", 32'(prod_ready), 1);
        feed(16'd7);
        for (int i = 0; i < 3; i++) tick();
        chk("stall_still_busy", 32'(out_valid), 0);
        feed(16'd9);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_acc", 32'(acc), 16);
            tick();
        end
        chk("stall_ovf17_cleared", 32'(ovf_s), 0);
        out_ready = 1'b1;
        tick();
        chk("hold_exit", 32'(out_valid), 0);

        // len = 0 completes immediately with a cleared result
        out_ready = 1'b0;
        begin_run(8'd0);
        chk("len0_valid", 32'(out_valid), 1);
        chk("len0_acc", 32'(acc), 0);
        chk("len0_ovf", 32'(ovf), 0);
        chk("len0_prod_ready", 32'(prod_ready), 0);
        out_ready = 1'b1;
        tick();
        chk("len0_exit", 32'(busy), 0);

        // start during ACCUM ignored, start during DONE handshake dropped
        out_ready = 1'b0;
        begin_run(8'd3);
        feed(16'd1);
        start = 1'b1;
        len   = 8'd9;
        feed(16'd2);
        start = 1'b0;
        feed(16'd3);
        chk("ign_valid", 32'(out_valid), 1);
        chk("ign_acc", 32'(acc), 6);
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd5;
        tick();
        start = 1'b0;
        chk("drop_busy", 32'(busy), 0);
        chk("drop_valid", 32'(out_valid), 0);
        tick();
        chk("drop_still_idle", 32'(busy), 0);
        chk("drop_acc_kept", 32'(acc), 6);

        // reset mid-run discards the partial sum
        begin_run(8'd5);
        feed(16'd10);
        feed(16'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_acc", 32'(acc), 0);
        chk("mrst_ovf", 32'(ovf), 0);
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_prod_ready", 32'(prod_ready), 0);
        chk("mrst_busy", 32'(busy), 0);
        out_ready = 1'b0;
        begin_run(8'd1);
        feed(16'd42);
        chk("fresh_valid", 32'(out_valid), 1);
        chk("fresh_acc", 32'(acc), 42);
        out_ready = 1'b1;
        tick();
        chk("fresh_exit", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 parallel multiplier.
- Consumes its 16-bit products through a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the dot-product-style result through a held output handshake.
- Provides the MAC back-end for filter and dot-product datapaths built on the combinational multiplier.

Parameters:
- PROD_W, 16, width of incoming product; matches multiplier output.
- ACC_W, 24, accumulator width; must be >= PROD_W.
- LEN_W, 8, width of the programmed product count.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a new accumulation; sampled in IDLE only.
- len  input  LEN_W  number of products to sum; sampled with start.
- prod  input  PROD_W  unsigned product from multiplier.
- prod_valid  input  1  prod is valid this cycle.
- prod_ready  output  1  block accepts prod this cycle.
- acc  output  ACC_W  accumulated sum; valid when out_valid.
- ovf  output  1  sticky: accumulation wrapped at least once during this run.
- out_valid  output  1  result available; held until taken.
- out_ready  input  1  downstream takes result.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, acc=0, ovf=0, internal count=0, prod_ready=0, out_valid=0, busy=0. Reset mid-operation aborts the run; partial sum is discarded.
- States:
  - IDLE: start=1 latches len into count, clears acc and ovf. Next state is ACCUM if len!=0, DONE if len==0 (result 0, ovf 0, out_valid one cycle after start).
  - ACCUM: prod_ready=1 (combinational from state). A transfer occurs when prod_valid && prod_ready at an edge: acc <= acc + zero-extended prod, modulo 2^ACC_W; ovf <= ovf | carry-out; count <= count-1. When the transfer has count==1, next state is DONE. prod_valid=0 cycles stall; no state change.
  - DONE: out_valid=1 with acc and ovf stable. A cycle with out_ready=1 completes the transfer; next state is IDLE. acc/ovf keep their values until the next start.
- Latency: out_valid rises on the cycle after the edge that accepted the last product.
- Throughput: one product per cycle in ACCUM; minimum run of N products is N+1 cycles plus handshake.
- start outside IDLE is ignored; len is not re-sampled.
- start and out_ready in the same cycle while in DONE: only the out handshake is honoured; start is dropped, and the requester retries in IDLE.
- prod_ready=0 outside ACCUM; prod_valid there has no effect.
- Arithmetic: unsigned; wrap on overflow, never saturate; ovf sticky per run.
- len=2^LEN_W-1 is supported; the full-scale sum must fit or flag ovf correctly.

Decomposition:
- Shared package mac_pkg holds:
  - state enum (IDLE, ACCUM, DONE), encoded in 2 bits;
  - default width constants PROD_W=16, ACC_W=24, LEN_W=8.
- One sub-module, acc_adder: ACC_W-bit carry-lookahead adder (sum, cout) built from the team's 8-bit CLA slices. Used for acc + prod with cout feeding ovf.
- Control FSM and counter stay in product_accumulator.

Test Plan:
- Basic sum: start with len=4, feed prod 100, 200, 300, 400 back-to-back, out_ready=1 -> out_valid on the cycle after the 4th accept; acc=1000, ovf=0; next cycle IDLE.
- Overflow (ACC_W=17 override): len=3, prod=65535 three times -> acc=65533 (196605 mod 131072), ovf=1.
- Stalls and backpressure: len=2, prod_valid gaps of 3 cycles, prods 7 and 9; out_ready low for 5 cycles -> acc=16 and out_valid held stable throughout; exits on the out_ready=1 cycle.
- len=0: start with len=0 -> out_valid next cycle, acc=0, ovf=0; prod_ready never asserted.
- Ignored start: during ACCUM (len=3, prods 1,2,3), pulse start with len=9 -> run still ends after 3 products, acc=6. Also start together with out_ready in DONE is dropped -> IDLE, busy=0.
- Reset mid-run: len=5, after 2 products assert rst one cycle -> acc=0, ovf=0, out_valid=0, prod_ready=0, IDLE. A fresh run with len=1, prod=42 then gives acc=42.
